// File: rtl/inst_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the fetch PC and drives a synchronous instruction SRAM whose data
// returns one cycle after the address.
// A one-entry skid buffer keeps the in-flight word when ID stalls.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | no read in flight, skid buffer empty
// S_PEND  | read issued last cycle, its data is on im_rdata now
// S_BUF   | skid buffer holds a fetched instruction, no read in flight
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_re,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_PEND  = 2'b01,
    S_BUF   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  assign im_addr  = pc_f_q;
  assign im_re    = !rst && !redirect_valid && !stall;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

  // Next-state: redirect beats stall, stall beats advance; hold by default.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pend_pc_d  = pend_pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    if (redirect_valid) begin
      // In-flight read and buffered word are simply abandoned.
      pc_f_d     = {redirect_pc[31:2], 2'b00};
      state_d    = S_EMPTY;
      id_valid_d = 1'b0;
      id_pc_d    = 32'h0;
      id_inst_d  = NOP_INST;
    end else if (stall) begin
      // Capture the returning word so it survives the stall.
      if (state_q == S_PEND) begin
        buf_inst_d = im_rdata;
        buf_pc_d   = pend_pc_q;
        state_d    = S_BUF;
      end
    end else begin
      case (state_q)
        S_BUF: begin
          id_valid_d = 1'b1;
          id_pc_d    = buf_pc_q;
          id_inst_d  = buf_inst_q;
        end
        S_PEND: begin
          id_valid_d = 1'b1;
          id_pc_d    = pend_pc_q;
          id_inst_d  = im_rdata;
        end
        default: begin
          id_valid_d = 1'b0;
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
        end
      endcase
      pend_pc_d = pc_f_q;
      pc_f_d    = pc_f_q + 32'd4;
      state_d   = S_PEND;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      pc_f_q     <= RESET_PC;
      pend_pc_q  <= 32'h0;
      buf_inst_q <= NOP_INST;
      buf_pc_q   <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pend_pc_q  <= pend_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: two instances (reset PC 0 and FFFF_FFF8) share
// one stimulus stream; each has its own SRAM model and reference model.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;

  logic        re0, re1, v0, v1;
  logic [31:0] addr0, addr1, rd0, rd1, pc0, pc1, inst0, inst1;

  int n_chk  = 0;
  int n_pass = 0;
  int cycle  = 0;

  // Reference model: "have" is a fetched instruction not yet in ID.
  logic [31:0] m_next [2];
  logic [31:0] m_have_pc [2];
  bit          m_have [2];
  bit          m_idv [2];
  logic [31:0] m_idpc [2];
  logic [31:0] m_idinst [2];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .im_re(re0), .im_addr(addr0), .im_rdata(rd0),
    .id_valid(v0), .id_pc(pc0), .id_inst(inst0)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .im_re(re1), .im_addr(addr1), .im_rdata(rd1),
    .id_valid(v1), .id_pc(pc1), .id_inst(inst1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + ((a >> 2) << 20) + (a >> 12);
  endfunction

  function automatic logic [31:0] reset_pc_of(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  // Synchronous SRAMs; garbage when not read so stale sampling shows up.
  always @(posedge clk) rd0 <= re0 ? mem_word(addr0) : $urandom();
  always @(posedge clk) rd1 <= re1 ? mem_word(addr1) : $urandom();

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cycle, got, exp);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_next[k] = reset_pc_of(k);
        m_have[k] = 1'b0;
        m_idv[k] = 1'b0; m_idpc[k] = 32'h0; m_idinst[k] = NOP;
      end else if (redirect_valid) begin
        m_next[k] = redirect_pc & 32'hFFFF_FFFC;
        m_have[k] = 1'b0;
        m_idv[k] = 1'b0; m_idpc[k] = 32'h0; m_idinst[k] = NOP;
      end else if (!stall) begin
        if (m_have[k]) begin
          m_idv[k] = 1'b1; m_idpc[k] = m_have_pc[k]; m_idinst[k] = mem_word(m_have_pc[k]);
        end else begin
          m_idv[k] = 1'b0; m_idpc[k] = 32'h0; m_idinst[k] = NOP;
        end
        m_have[k] = 1'b1;
        m_have_pc[k] = m_next[k];
        m_next[k] = m_next[k] + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rv, input logic [31:0] rp, input bit st);
    logic exp_re;
    rst = r; redirect_valid = rv; redirect_pc = rp; stall = st;
    exp_re = !r && !rv && !st;
    #1;
    chk("im_re0", {31'h0, re0}, {31'h0, exp_re});
    chk("im_re1", {31'h0, re1}, {31'h0, exp_re});
    chk("im_addr0", addr0, m_next[0]);
    chk("im_addr1", addr1, m_next[1]);
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    chk("id_valid0", {31'h0, v0}, {31'h0, m_idv[0]});
    chk("id_pc0", pc0, m_idpc[0]);
    chk("id_inst0", inst0, m_idinst[0]);
    chk("id_valid1", {31'h0, v1}, {31'h0, m_idv[1]});
    chk("id_pc1", pc1, m_idpc[1]);
    chk("id_inst1", inst1, m_idinst[1]);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    model_edge();
    #1;
    cyc(1, 0, 0, 0);

    // Reset then stream: dut1 also shows FFFF_FFF8, FFFF_FFFC, 0.
    repeat (4) cyc(0, 0, 0, 0);
    chk("stream_pc0_at_8", pc0, 32'h8);
    chk("wrap_pc1_at_0", pc1, 32'h0);

    // Stall three cycles while ID holds pc 8.
    repeat (3) begin
      cyc(0, 0, 0, 1);
      chk("stall_hold_pc0", pc0, 32'h8);
    end
    cyc(0, 0, 0, 0);
    chk("after_stall_pc0", pc0, 32'hC);

    // Redirect to 0x100 while ID holds pc 12.
    cyc(0, 1, 32'h0000_0100, 0);
    chk("redir_bubble_inst0", inst0, NOP);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("redir_target_pc0", pc0, 32'h100);
    cyc(0, 0, 0, 0);

    // Enter BUF, then stall plus redirect to 0x202.
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h0000_0202, 1);
    repeat (2) cyc(0, 0, 0, 0);
    chk("redir_stall_pc0", pc0, 32'h200);
    cyc(0, 0, 0, 0);

    // Reset for one cycle while in PEND.
    cyc(1, 0, 0, 0);
    chk("midrst_addr1", addr1, 32'hFFFF_FFF8);
    repeat (4) cyc(0, 0, 0, 0);

    // Random mix of stalls, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      int p;
      p = $urandom_range(0, 99);
      cyc(p < 2, (p >= 2) && (p < 12), $urandom(), ($urandom_range(0, 99) < 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage with IF/ID pipeline register for the RV32I core. Holds the PC and issues reads to the synchronous instruction SRAM (data returns one cycle after the address). Delivers `{pc, inst}` to decode, where `id_inst` feeds the decoder and the immediate extender. A one-entry skid buffer preserves the in-flight instruction across stalls; branch/jump redirects from EX flush the stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Bits [1:0] must be 0.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): value driven on `id_inst` when the stage is invalid.

Ports:
- `clk`  in  1: sole clock. All state updates on its rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `stall`  in  1: hazard unit stall. While high, the ID register is held and no new fetch is issued.
- `redirect_valid`  in  1: taken branch, jal or jalr resolved in EX.
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored and treated as 0.
- `im_re`  out  1: instruction SRAM read enable.
- `im_addr`  out  32: instruction SRAM byte address. Equals the current fetch PC.
- `im_rdata`  in  32: SRAM read data. Valid the cycle after an `im_re` cycle.
- `id_valid`  out  1: the IF/ID register holds a real instruction.
- `id_pc`  out  32: PC of `id_inst`.
- `id_inst`  out  32: instruction to decode.

## Operation
- Internal state:
  - `pc_f`: next address to fetch.
  - `pend_pc`: PC of the read in flight.
  - `buf_inst`, `buf_pc`: skid buffer.
  - FSM with states EMPTY, PEND and BUF.
- State meanings:
  - EMPTY: no read in flight and the buffer is empty.
  - PEND: a read issued last cycle, its data is on `im_rdata` this cycle.
  - BUF: the buffer holds a fetched instruction and no read is in flight.
- Combinational outputs:
  - `im_addr = pc_f`.
  - `im_re = !rst && !redirect_valid && !stall`.
- Priority order: `rst` > `redirect_valid` > `stall` > advance.
- Redirect, from any state:
  - `pc_f <= {redirect_pc[31:2],2'b00}`. State goes to EMPTY.
  - The in-flight read is discarded. `buf` is discarded.
  - `id_valid <= 0`, `id_inst <= NOP_INST`, `id_pc <= 0`.
  - A redirect overrides a simultaneous `stall`.
- Stall, no redirect:
  - The ID register and `pc_f` are held.
  - PEND → BUF: `buf_inst <= im_rdata`, `buf_pc <= pend_pc`.
  - EMPTY stays EMPTY. BUF stays BUF.
- Advance (neither `stall` nor redirect):
  - The ID register loads from the current source:
    - BUF: loads `buf_inst`/`buf_pc`, with `id_valid <= 1`.
    - PEND: loads `im_rdata`/`pend_pc`, with `id_valid <= 1`.
    - EMPTY: loads `NOP_INST`/0, with `id_valid <= 0`.
  - A read issues at `pc_f`: `pend_pc <= pc_f`, `pc_f <= pc_f + 4`. State goes to PEND.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values, applied on any clock edge with `rst`=1:
  - `pc_f = RESET_PC`, state EMPTY.
  - `id_valid = 0`, `id_pc = 0`, `id_inst = NOP_INST`.
  - `im_re = 0` during reset.
- Reset mid-operation drops everything: in-flight read, buffer and ID register.
- Startup: the first cycle after reset deassertion issues `RESET_PC`. The instruction is in ID (`id_valid=1`) after the 2nd edge.
- Steady state: one instruction per cycle, with `id_pc` incrementing by 4.
- Stall of N cycles: the ID register is frozen for exactly N edges. After release there is no bubble, because the buffered instruction enters ID on the release edge.
- Redirect asserted in cycle R:
  - ID is invalid after edges R and R+1.
  - The target instruction is in ID after edge R+2.
  - Penalty is 2 bubbles.
- A redirect in the same cycle as the last stall cycle behaves as a plain redirect.
- `im_rdata` is only sampled in PEND. It is don't-care otherwise.

## Test plan
- Reset then stream:
  - Stimulus: `RESET_PC`=0, memory word i = 32'h0010_0093+(i<<20), `stall`=0.
  - Required: `im_addr` 0,4,8,… from the first cycle after reset. ID shows pc 0,4,8 with the matching words starting the 2nd edge. `id_valid` is 0 before that.
- Stall mid-stream:
  - Stimulus: `stall`=1 for 3 cycles while ID holds pc 8.
  - Required: ID holds pc 8 for 3 edges and `im_re`=0. Then ID shows pc 12, 16 back-to-back with no gap and no duplicate.
- Redirect:
  - Stimulus: `redirect_valid`=1, `redirect_pc`=32'h0000_0100 while ID holds pc 12.
  - Required: `id_valid`=0 with `id_inst`=32'h0000_0013 for 2 edges. Then pc 0x100, 0x104. Pc 16 never appears.
- Redirect during stall:
  - Stimulus: state BUF, assert `stall` and `redirect_valid` together, `redirect_pc`=32'h0000_0202.
  - Required: the buffer is dropped. Fetch resumes at 0x200, with the low bits cleared.
- Wrap and reset mid-run:
  - Stimulus: `RESET_PC`=32'hFFFF_FFF8.
  - Required: ID pcs are FFFF_FFF8, FFFF_FFFC, 0.
  - Stimulus: assert `rst` for 1 cycle while in PEND.
  - Required: after that edge, `id_valid`=0 and `pc_f`=`RESET_PC`, and fetching restarts from `RESET_PC`.
